jesd_tx_link_ctrl: RTL and testbench
====================================

Name: jesd_tx_link_ctrl

Overview:
Transmit-side JESD204B link-establishment controller. It sequences the lane framer through three phases: Code Group Synchronisation (CGS), Initial Lane Alignment Sequence (ILAS) and user DATA. Phase changes are driven by the receiver's SYNC~ and by the single-cycle frame and LMFC pulses of the local frame/LMFC clock generator. It sits between that generator and the per-lane framer/scrambler, and also reports SYNC~ error requests and resynchronisation events.

Parameters:
ILAS_MF, 4, number of ILAS multiframes (legal 1..8)
RESYNC_FRAMES, 4, consecutive frame pulses with SYNC~ low that force a resync (legal 2..15)
SYNC_STAGES, 2, synchroniser depth on i_sync_n (legal 2..3)

Ports:
clk  in  1  device clock
rst  in  1  asynchronous reset, active-high
i_enable  in  1  link enable; 0 forces CGS
i_sync_n  in  1  SYNC~ from receiver, asynchronous, active-low
i_frame_pulse  in  1  one-cycle pulse, last device-clock cycle of each frame
i_lmfc_pulse  in  1  one-cycle pulse, last device-clock cycle of each multiframe
o_mode  out  2  framer select: 0=CGS (/K/), 1=ILAS, 2=DATA (3 unused)
o_mf_idx  out  3  ILAS multiframe index 0..ILAS_MF-1; 0 outside ILAS
o_mf_start  out  1  high on first cycle of each ILAS multiframe
o_link_up  out  1  high while o_mode==DATA
o_err_pulse  out  1  one-cycle error-report strobe
o_err_cnt  out  8  saturating count of error reports
o_resync_cnt  out  8  saturating count of resyncs from ILAS/DATA

Behaviour:
- Reset (async assert, sync release): o_mode=CGS, o_mf_idx=0, o_mf_start=0, o_link_up=0, o_err_pulse=0, o_err_cnt=0, o_resync_cnt=0, synchroniser flops=0 (SYNC~ asserted), low-frame counter=0.
- All outputs are registered. sync_s is i_sync_n after SYNC_STAGES flops.
- CGS: o_mode=0. Transition to ILAS when i_enable && sync_s==1 && i_lmfc_pulse. On the next cycle o_mode=1, o_mf_idx=0, o_mf_start=1. This aligns ILAS to the first cycle of a multiframe.
- ILAS: on each i_lmfc_pulse:
  - if o_mf_idx<ILAS_MF-1: increment o_mf_idx, o_mf_start=1 next cycle.
  - if o_mf_idx==ILAS_MF-1: go to DATA. Next cycle o_mode=2, o_link_up=1, o_mf_idx=0.
  - o_mf_start is 0 on all other cycles.
- DATA: hold until a resync or disable.
- Low-frame counter (4-bit), active in ILAS/DATA only:
  - While sync_s==0, increment on each i_frame_pulse.
  - When it reaches RESYNC_FRAMES: next cycle go to CGS, clear o_mf_idx, o_link_up and the counter, and increment o_resync_cnt (saturates at 255).
  - If sync_s rises with counter in 1..RESYNC_FRAMES-1: o_err_pulse=1 for one cycle, o_err_cnt+1 (saturates), counter cleared, state unchanged.
  - A low period containing no frame pulse (count 0) is ignored.
  - The counter is held at 0 in CGS.
- i_enable=0 in any state: next cycle CGS, same clears as resync. o_resync_cnt is not incremented.
- Priority in one cycle: disable > resync > LMFC advance. Example: if the resync threshold and i_lmfc_pulse coincide in ILAS, go to CGS.
- sync_s==1 with no lmfc pulse: remain in CGS indefinitely.
- Reset mid-ILAS/DATA: immediate return to reset values.

Decomposition:
- jesd204b_pkg holds:
  - mode localparams MODE_CGS=2'd0, MODE_ILAS=2'd1, MODE_DATA=2'd2
  - state encoding (3 states, one-hot or binary)
  - default ILAS_MF/RESYNC_FRAMES constants
- One sub-module, jesd_sync_n_sync: SYNC_STAGES-deep synchroniser, async reset to 0, reusable on the RX side.

Test Plan:
- Bring-up: frame pulse every 2 clk, lmfc every 16 clk. Release SYNC~ at cycle 20. → o_mode=1 starting the cycle after the first lmfc pulse seen with sync_s=1; o_mf_start at indices 0,1,2,3, 16 clk apart; o_mode=2 and o_link_up=1 exactly 64 clk after ILAS entry.
- Short error: in DATA, hold SYNC~ low across 2 frame pulses, then release. → one o_err_pulse, o_err_cnt=1, o_mode stays 2.
- Resync: in DATA, hold SYNC~ low across 4 frame pulses. → o_mode=0 the cycle after the 4th counted pulse, o_resync_cnt=1; releasing SYNC~ re-runs ILAS on the next LMFC boundary.
- Collision: in ILAS at o_mf_idx=3, make the 4th low frame pulse coincide with i_lmfc_pulse. → o_mode=0, never 2.
- Disable/reset: drop i_enable in ILAS → CGS next cycle with o_resync_cnt unchanged. Assert rst mid-DATA → all outputs at reset values with no clock edge.
- Saturation: force 300 short errors. → o_err_cnt stays at 255, o_err_pulse still strobes for each error.

Source files
------------

// File: rtl/jesd204b_pkg.sv
// Shared constants and helpers for the JESD204B transmit link controller
// and its synchroniser.
package jesd204b_pkg;

  // Framer mode select values presented on o_mode.
  localparam logic [1:0] MODE_CGS  = 2'd0;
  localparam logic [1:0] MODE_ILAS = 2'd1;
  localparam logic [1:0] MODE_DATA = 2'd2;

  // One-hot link state encoding; any other pattern is treated as illegal.
  localparam logic [2:0] ST_CGS  = 3'b001;
  localparam logic [2:0] ST_ILAS = 3'b010;
  localparam logic [2:0] ST_DATA = 3'b100;

  // Default parameter values.
  localparam int ILAS_MF_DEF       = 4;
  localparam int RESYNC_FRAMES_DEF = 4;
  localparam int SYNC_STAGES_DEF   = 2;

  // Increment an 8-bit event counter, sticking at all-ones.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'hFF) begin
      r = v;
    end else begin
      r = v + 8'd1;
    end
    return r;
  endfunction

  // Map a link state onto the framer mode it drives.
  function automatic logic [1:0] state_to_mode(input logic [2:0] st);
    logic [1:0] m;
    case (st)
      ST_ILAS: m = MODE_ILAS;
      ST_DATA: m = MODE_DATA;
      default: m = MODE_CGS;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/jesd_sync_n_sync.sv
// Multi-flop synchroniser for the asynchronous SYNC~ line. Resets to 0 so
// that SYNC~ reads as asserted (link requesting CGS) until proven otherwise.
module jesd_sync_n_sync
  import jesd204b_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync
);

  logic [STAGES-1:0] sync_q;

  // Shift the raw input through the synchroniser chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], i_async};
    end
  end

  assign o_sync = sync_q[STAGES-1];

endmodule

// File: rtl/jesd_tx_link_ctrl.sv
// JESD204B transmit link-establishment controller. Steps the framer
// through CGS, ILAS and DATA using SYNC~ and the local frame/LMFC pulses,
// watches SYNC~ for error reports and resynchronisation requests.
module jesd_tx_link_ctrl
  import jesd204b_pkg::*;
#(
  parameter int ILAS_MF       = ILAS_MF_DEF,
  parameter int RESYNC_FRAMES = RESYNC_FRAMES_DEF,
  parameter int SYNC_STAGES   = SYNC_STAGES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_enable,
  input  logic       i_sync_n,
  input  logic       i_frame_pulse,
  input  logic       i_lmfc_pulse,
  output logic [1:0] o_mode,
  output logic [2:0] o_mf_idx,
  output logic       o_mf_start,
  output logic       o_link_up,
  output logic       o_err_pulse,
  output logic [7:0] o_err_cnt,
  output logic [7:0] o_resync_cnt
);

  // Index of the final ILAS multiframe and the low-frame count one short
  // of a resync; reaching the latter with another low frame forces CGS.
  localparam logic [2:0] MF_LAST     = 3'(ILAS_MF - 1);
  localparam logic [3:0] RESYNC_LAST = 4'(RESYNC_FRAMES - 1);

  logic       sync_s;
  logic       link_active_s;
  logic       low_frame_s;
  logic       resync_s;
  logic       short_err_s;

  logic [2:0] state_q,      state_d;
  logic [1:0] mode_q,       mode_d;
  logic [2:0] mf_idx_q,     mf_idx_d;
  logic       mf_start_q,   mf_start_d;
  logic       link_up_q,    link_up_d;
  logic       err_pulse_q,  err_pulse_d;
  logic [7:0] err_cnt_q,    err_cnt_d;
  logic [7:0] resync_cnt_q, resync_cnt_d;
  logic [3:0] low_cnt_q,    low_cnt_d;

  jesd_sync_n_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (i_sync_n),
    .o_sync  (sync_s)
  );

  // SYNC~ supervision only matters once the link has left CGS. A frame
  // pulse with SYNC~ low extends the low period; if SYNC~ is seen high
  // while the count is non-zero the low period was short, i.e. an error
  // report. The count never holds RESYNC_FRAMES because that event clears it.
  assign link_active_s = (state_q == ST_ILAS) || (state_q == ST_DATA);
  assign low_frame_s   = link_active_s && !sync_s && i_frame_pulse;
  assign resync_s      = low_frame_s && (low_cnt_q == RESYNC_LAST);
  assign short_err_s   = link_active_s && sync_s && (low_cnt_q != 4'd0);

  // Next-state logic: disable beats resync, resync beats LMFC advance.
  always_comb begin
    state_d      = state_q;
    mf_idx_d     = mf_idx_q;
    mf_start_d   = 1'b0;
    err_pulse_d  = 1'b0;
    err_cnt_d    = err_cnt_q;
    resync_cnt_d = resync_cnt_q;
    low_cnt_d    = low_cnt_q;

    if (!i_enable) begin
      state_d   = ST_CGS;
      mf_idx_d  = 3'd0;
      low_cnt_d = 4'd0;
    end else if (resync_s) begin
      state_d      = ST_CGS;
      mf_idx_d     = 3'd0;
      low_cnt_d    = 4'd0;
      resync_cnt_d = sat_inc8(resync_cnt_q);
    end else begin
      if (short_err_s) begin
        err_pulse_d = 1'b1;
        err_cnt_d   = sat_inc8(err_cnt_q);
        low_cnt_d   = 4'd0;
      end else if (low_frame_s) begin
        low_cnt_d = low_cnt_q + 4'd1;
      end else begin
        low_cnt_d = low_cnt_q;
      end

      case (state_q)
        ST_CGS: begin
          low_cnt_d = 4'd0;
          // Entering on the LMFC pulse lines ILAS up with a multiframe start.
          if (sync_s && i_lmfc_pulse) begin
            state_d    = ST_ILAS;
            mf_idx_d   = 3'd0;
            mf_start_d = 1'b1;
          end else begin
            state_d = ST_CGS;
          end
        end
        ST_ILAS: begin
          if (i_lmfc_pulse) begin
            if (mf_idx_q == MF_LAST) begin
              state_d  = ST_DATA;
              mf_idx_d = 3'd0;
            end else begin
              mf_idx_d   = mf_idx_q + 3'd1;
              mf_start_d = 1'b1;
            end
          end else begin
            state_d = ST_ILAS;
          end
        end
        ST_DATA: begin
          state_d = ST_DATA;
        end
        default: begin
          state_d   = ST_CGS;
          mf_idx_d  = 3'd0;
          low_cnt_d = 4'd0;
        end
      endcase
    end

    mode_d    = state_to_mode(state_d);
    link_up_d = (state_d == ST_DATA);
  end

  // Register state and every output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_CGS;
      mode_q       <= MODE_CGS;
      mf_idx_q     <= 3'd0;
      mf_start_q   <= 1'b0;
      link_up_q    <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_cnt_q    <= 8'd0;
      resync_cnt_q <= 8'd0;
      low_cnt_q    <= 4'd0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      mf_idx_q     <= mf_idx_d;
      mf_start_q   <= mf_start_d;
      link_up_q    <= link_up_d;
      err_pulse_q  <= err_pulse_d;
      err_cnt_q    <= err_cnt_d;
      resync_cnt_q <= resync_cnt_d;
      low_cnt_q    <= low_cnt_d;
    end
  end

  assign o_mode       = mode_q;
  assign o_mf_idx     = mf_idx_q;
  assign o_mf_start   = mf_start_q;
  assign o_link_up    = link_up_q;
  assign o_err_pulse  = err_pulse_q;
  assign o_err_cnt    = err_cnt_q;
  assign o_resync_cnt = resync_cnt_q;

endmodule

// File: tb/tb_jesd_tx_link_ctrl.sv
// Bench for jesd_tx_link_ctrl: directed link scenarios with randomised
// SYNC~/enable timing, every cycle compared against a behavioural model.
module tb_jesd_tx_link_ctrl;

  localparam int ILAS_MF       = 4;
  localparam int RESYNC_FRAMES = 4;
  localparam int SYNC_STAGES   = 2;
  localparam int LMFC_LEN      = 16;

  logic       clk           = 1'b0;
  logic       rst           = 1'b1;
  logic       i_enable      = 1'b0;
  logic       i_sync_n      = 1'b0;
  logic       i_frame_pulse = 1'b0;
  logic       i_lmfc_pulse  = 1'b0;
  logic [1:0] o_mode;
  logic [2:0] o_mf_idx;
  logic       o_mf_start;
  logic       o_link_up;
  logic       o_err_pulse;
  logic [7:0] o_err_cnt;
  logic [7:0] o_resync_cnt;

  jesd_tx_link_ctrl #(
    .ILAS_MF       (ILAS_MF),
    .RESYNC_FRAMES (RESYNC_FRAMES),
    .SYNC_STAGES   (SYNC_STAGES)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_enable      (i_enable),
    .i_sync_n      (i_sync_n),
    .i_frame_pulse (i_frame_pulse),
    .i_lmfc_pulse  (i_lmfc_pulse),
    .o_mode        (o_mode),
    .o_mf_idx      (o_mf_idx),
    .o_mf_start    (o_mf_start),
    .o_link_up     (o_link_up),
    .o_err_pulse   (o_err_pulse),
    .o_err_cnt     (o_err_cnt),
    .o_resync_cnt  (o_resync_cnt)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int tcnt     = 0;

  // Behavioural model: phase 0=CGS 1=ILAS 2=DATA, plus the SYNC~ delay line.
  int m_phase, m_mf, m_low, m_err, m_resync;
  bit m_start, m_errp;
  bit m_sync [SYNC_STAGES];

  // Observation records.
  int         starts[$];
  int         ilas_t    = -1;
  int         data_t    = -1;
  int         err_seen  = 0;
  bit         seen_data = 1'b0;
  logic [1:0] prev_mode = 2'd0;
  int         saved;
  int         e0;
  int         k;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_mf = 0; m_low = 0; m_err = 0; m_resync = 0;
    m_start = 1'b0; m_errp = 1'b0;
    for (int i = 0; i < SYNC_STAGES; i++) m_sync[i] = 1'b0;
  endtask

  // One device-clock edge of the link rules, using pre-edge inputs.
  task automatic model_edge();
    bit ss;
    bit act;
    if (rst) begin
      model_reset();
      return;
    end
    ss = m_sync[SYNC_STAGES-1];
    for (int i = SYNC_STAGES - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
    m_sync[0] = i_sync_n;
    act = (m_phase != 0);
    m_start = 1'b0;
    m_errp  = 1'b0;
    if (!i_enable) begin
      m_phase = 0; m_mf = 0; m_low = 0;
    end else if (act && !ss && i_frame_pulse && (m_low + 1 == RESYNC_FRAMES)) begin
      m_phase = 0; m_mf = 0; m_low = 0;
      m_resync = (m_resync < 255) ? m_resync + 1 : 255;
    end else begin
      if (act && ss && m_low > 0) begin
        m_errp = 1'b1;
        m_err  = (m_err < 255) ? m_err + 1 : 255;
        m_low  = 0;
      end else if (act && !ss && i_frame_pulse) begin
        m_low = m_low + 1;
      end
      if (m_phase == 0) begin
        if (ss && i_lmfc_pulse) begin
          m_phase = 1; m_mf = 0; m_start = 1'b1;
        end
      end else if (m_phase == 1 && i_lmfc_pulse) begin
        if (m_mf == ILAS_MF - 1) begin
          m_phase = 2; m_mf = 0;
        end else begin
          m_mf = m_mf + 1; m_start = 1'b1;
        end
      end
    end
  endtask

  function automatic logic [23:0] exp_vec();
    return {2'(m_phase), 3'(m_mf), m_start, (m_phase == 2), m_errp, 8'(m_err), 8'(m_resync)};
  endfunction

  function automatic logic [23:0] obs_vec();
    return {o_mode, o_mf_idx, o_mf_start, o_link_up, o_err_pulse, o_err_cnt, o_resync_cnt};
  endfunction

  // Advance n clocks with free-running frame (every 2) and LMFC (every 16) pulses.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      i_frame_pulse = ((tcnt % 2) == 1);
      i_lmfc_pulse  = ((tcnt % LMFC_LEN) == LMFC_LEN - 1);
      @(posedge clk);
      model_edge();
      #1;
      check($sformatf("cycle%0d", tcnt), 32'(obs_vec()), 32'(exp_vec()));
      if (o_mf_start === 1'b1) starts.push_back(tcnt);
      if (o_err_pulse === 1'b1) err_seen++;
      if (o_mode === 2'd2) seen_data = 1'b1;
      if (o_mode === 2'd1 && prev_mode === 2'd0 && ilas_t < 0) ilas_t = tcnt;
      if (o_mode === 2'd2 && prev_mode === 2'd1 && data_t < 0) data_t = tcnt;
      prev_mode = o_mode;
      tcnt++;
    end
  endtask

  task automatic wait_mode(input logic [1:0] m, input int budget, input string tag);
    int n = 0;
    while (o_mode !== m && n < budget) begin
      step(1);
      n++;
    end
    check(tag, 32'(o_mode), 32'(m));
  endtask

  initial begin
    model_reset();
    i_enable = 1'b1;
    i_sync_n = 1'b0;
    rst      = 1'b1;
    step(3);
    check("reset_state", 32'(obs_vec()), 32'd0);
    rst = 1'b0;

    // Bring-up: SYNC~ released at cycle 20; first LMFC seen with sync_s=1 is edge 31.
    step(20 - tcnt);
    i_sync_n = 1'b1;
    step(96 - tcnt);
    check("ilas_entry", 32'(ilas_t), 32'd31);
    check("ilas_len", 32'(data_t - ilas_t), 32'(ILAS_MF * LMFC_LEN));
    check("mf_start_n", 32'(starts.size()), 32'(ILAS_MF));
    foreach (starts[j]) check("mf_start_t", 32'(starts[j]), 32'(31 + LMFC_LEN * j));
    check("link_up", 32'(o_link_up), 32'd1);

    // Short error: two low frames then release.
    i_sync_n = 1'b0; step(4);
    i_sync_n = 1'b1; step(6);
    check("short_err_pulses", 32'(err_seen), 32'd1);
    check("short_err_cnt", 32'(o_err_cnt), 32'd1);
    check("short_err_mode", 32'(o_mode), 32'd2);

    // Random short low periods, including ones too short to hold a frame pulse.
    for (int r = 0; r < 6; r++) begin
      i_sync_n = 1'b0; step(int'($urandom_range(1, 5)));
      i_sync_n = 1'b1; step(int'($urandom_range(3, 8)));
    end

    // Resync: four low frames.
    check("pre_resync_mode", 32'(o_mode), 32'd2);
    i_sync_n = 1'b0; step(8);
    i_sync_n = 1'b1;
    wait_mode(2'd0, 4, "resync_mode");
    check("resync_cnt", 32'(o_resync_cnt), 32'd1);
    wait_mode(2'd1, 40, "reilas");
    wait_mode(2'd2, 80, "redata");

    // Disable in DATA and in ILAS: back to CGS, resync count untouched.
    saved = int'(o_resync_cnt);
    i_enable = 1'b0; step(1);
    check("dis_data_mode", 32'(o_mode), 32'd0);
    i_enable = 1'b1;
    wait_mode(2'd1, 40, "dis_reilas");
    step(3);
    i_enable = 1'b0; step(1);
    check("dis_ilas_mode", 32'(o_mode), 32'd0);
    check("dis_ilas_resync", 32'(o_resync_cnt), 32'(saved));
    i_enable = 1'b1;

    // Collision: 4th low frame lands on the LMFC that would end ILAS.
    k = 0;
    while (!(o_mode === 2'd1 && o_mf_idx === 3'd3) && k < 120) begin
      step(1);
      k++;
    end
    check("coll_idx3", 32'({o_mode, o_mf_idx}), 32'({2'd1, 3'd3}));
    check("coll_phase", 32'(tcnt % LMFC_LEN), 32'd0);
    step(7);
    i_sync_n  = 1'b0;
    seen_data = 1'b0;
    step(9);
    check("coll_mode", 32'(o_mode), 32'd0);
    check("coll_resync", 32'(o_resync_cnt), 32'(saved + 1));
    check("coll_no_data", 32'(seen_data), 32'd0);
    i_sync_n = 1'b1;
    wait_mode(2'd2, 150, "coll_recover");

    // Reset mid-DATA: outputs clear without a clock edge.
    step(5);
    rst = 1'b1;
    #2;
    check("rst_async", 32'(obs_vec()), 32'd0);
    model_reset();
    step(3);
    rst = 1'b0;
    wait_mode(2'd2, 200, "rst_rebring");
    check("rst_errcnt", 32'(o_err_cnt), 32'd0);

    // Saturation: 300 short errors.
    e0 = err_seen;
    for (int r = 0; r < 300; r++) begin
      i_sync_n = 1'b0; step(int'($urandom_range(2, 5)));
      i_sync_n = 1'b1; step(4);
    end
    check("sat_pulses", 32'(err_seen - e0), 32'd300);
    check("sat_cnt", 32'(o_err_cnt), 32'd255);
    check("sat_mode", 32'(o_mode), 32'd2);

    // Random soak of SYNC~ and enable.
    for (int r = 0; r < 80; r++) begin
      i_sync_n = ($urandom_range(0, 3) != 0);
      i_enable = ($urandom_range(0, 15) != 0);
      step(int'($urandom_range(1, 12)));
    end
    i_enable = 1'b1;
    step(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
